// File: rtl/pip_if_rv32.sv
// pip_if_rv32: RV32I instruction fetch with one-outstanding cache port and prefetch FIFO; define IF_MISALIGN_CHK_EN for misaligned-redirect fault.
module pip_if_rv32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic        oIMemREQ,
  output logic [31:0] oIMemADDR,
  input  logic        iIMemACK,
  input  logic        iIMemRVALID,
  input  logic [31:0] iIMemRDATA,
  input  logic        iREDIRECT,
  input  logic [31:0] iREDIRADDR,
  input  logic        iSTALL,
  output logic        oVALID,
  output logic [31:0] oINSTR,
  output logic [31:0] oPCADDR
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic        oFETCHFAULT
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  state_t state;
  logic [31:0] pc, req_pc, tgt;
  logic [31:0] fifo_pc [FIFO_DEPTH];
  logic [31:0] fifo_ins [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count, count_nxt;
  logic drop, fault, bad, redir, ack, rsp, push, pop;
`ifdef IF_MISALIGN_CHK_EN
  assign bad = iREDIRECT && !fault && iREDIRADDR[1:0] != 2'b00;
  assign oFETCHFAULT = fault;
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) fault <= 1'b0;
    else if (bad) fault <= 1'b1;
`else
  assign bad = 1'b0;
  assign fault = 1'b0;
`endif
  assign tgt = iREDIRADDR & 32'hFFFF_FFFC;
  assign redir = iREDIRECT && !fault;
  assign ack = state == S_REQ && iIMemACK;
  assign rsp = state == S_RESP && iIMemRVALID;
  // a response landing with a redirect belongs to the old stream
  assign push = rsp && !drop && !redir;
  assign pop = oVALID && !iSTALL && !redir;
  assign count_nxt = redir ? '0 : count + (PW+1)'(push) - (PW+1)'(pop);
  assign oIMemREQ = state == S_REQ;
  assign oIMemADDR = pc;
  assign oVALID = count != '0;
  assign oINSTR = oVALID ? fifo_ins[rd_ptr] : 32'h0000_0013;
  assign oPCADDR = fault ? pc : oVALID ? fifo_pc[rd_ptr] : 32'h0;
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      req_pc <= RESET_PC;
      drop <= 1'b0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count_nxt;
      rd_ptr <= redir ? '0 : rd_ptr + PW'(pop);
      wr_ptr <= redir ? '0 : wr_ptr + PW'(push);
      if (ack) req_pc <= pc;
      pc <= bad ? iREDIRADDR : redir ? tgt : ack ? pc + 32'd4 : pc;
      // an acked or in-flight request overtaken by a redirect must have its response discarded
      drop <= (redir && (ack || (state == S_RESP && !iIMemRVALID))) ? 1'b1 : rsp ? 1'b0 : drop;
      case (state)
        S_IDLE:  if (!redir && !fault && count < DEPTH) state <= S_REQ;
        S_REQ:   if (ack) state <= S_RESP;
        S_RESP:  if (rsp) state <= count_nxt < DEPTH ? S_REQ : S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (bad) state <= S_IDLE;
    end
  always_ff @(posedge iCLK)
    if (push) begin
      fifo_pc[wr_ptr] <= req_pc;
      fifo_ins[wr_ptr] <= iIMemRDATA;
    end
endmodule
